uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 16x-oversampled UART receiver, 5-8 data bits, 1/2 stop bits,
//            one-word output buffer with overrun. Define UART_RX_PARITY_EN
//            to add parity bit handling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic [1:0] data_bits_count,
    input  logic [1:0] parity_type,
    input  logic       double_stop_bits,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [1:0]             r_cfg_bits;
    logic                   r_cfg_stop2;
    logic                   r_frame_err_acc;
    logic                   r_par_err_acc;
    logic                   r_armed;
    logic [7:0]             r_dout;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;

    logic                   w_rx_s;
    logic                   w_mid_start;
    logic                   w_mid_bit;
    logic                   w_last_bit;
    logic                   w_start_ok;
    logic                   w_complete;
    logic                   w_frame_err_final;
    logic [7:0]             w_word;

`ifdef UART_RX_PARITY_EN
    logic                   r_cfg_par_en;
    logic                   r_cfg_par_odd;
    logic                   r_par_acc;
`else
    logic                   w_unused_parity;
    assign w_unused_parity = ^parity_type;
`endif

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_mid_start = sample_tick && (r_tick_cnt == 4'd7);
    assign w_mid_bit   = sample_tick && (r_tick_cnt == 4'd15);
    // Last data bit index is N-1 = 4 + data_bits_count.
    assign w_last_bit  = (r_bit_cnt == {1'b1, r_cfg_bits});
    assign w_start_ok  = (r_state == S_START) && w_mid_start && !w_rx_s;
    assign w_frame_err_final = r_frame_err_acc | ~w_rx_s;
    // Bits were shifted in from the top; right-align by the unused width.
    assign w_word      = r_shift >> (2'd3 - r_cfg_bits);

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick && !w_rx_s && r_armed)
                    w_state_next = S_START;
            end
            S_START: begin
                if (w_mid_start)
                    w_state_next = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_mid_bit && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = r_cfg_par_en ? S_PARITY : S_STOP;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_mid_bit)
                    w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_mid_bit) begin
                    if (r_cfg_stop2) begin
                        w_state_next = S_STOP2;
                    end else begin
                        w_state_next = S_IDLE;
                        w_complete   = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_mid_bit) begin
                    w_state_next = S_IDLE;
                    w_complete   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_sync          <= '1;
            r_tick_cnt      <= 4'd0;
            r_bit_cnt       <= 3'd0;
            r_shift         <= 8'd0;
            r_cfg_bits      <= 2'd0;
            r_cfg_stop2     <= 1'b0;
            r_frame_err_acc <= 1'b0;
            r_par_err_acc   <= 1'b0;
            r_armed         <= 1'b1;
            r_dout          <= 8'd0;
            r_valid         <= 1'b0;
            r_frame_err     <= 1'b0;
            r_parity_err    <= 1'b0;
            r_overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_cfg_par_en    <= 1'b0;
            r_cfg_par_odd   <= 1'b0;
            r_par_acc       <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_overrun <= 1'b0;

            // Counter wraps 15->0 at every mid-bit sample, so only IDLE and
            // the mid-start point need an explicit clear.
            if (sample_tick) begin
                if (r_state == S_IDLE || (r_state == S_START && r_tick_cnt == 4'd7))
                    r_tick_cnt <= 4'd0;
                else
                    r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            if (w_start_ok) begin
                r_cfg_bits      <= data_bits_count;
                r_cfg_stop2     <= double_stop_bits;
                r_shift         <= 8'd0;
                r_bit_cnt       <= 3'd0;
                r_frame_err_acc <= 1'b0;
                r_par_err_acc   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_cfg_par_en    <= parity_type[0];
                r_cfg_par_odd   <= parity_type[1];
                r_par_acc       <= 1'b0;
`endif
            end

            if (r_state == S_DATA && w_mid_bit) begin
                r_shift   <= {w_rx_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                r_par_acc <= r_par_acc ^ w_rx_s;
`endif
            end

`ifdef UART_RX_PARITY_EN
            if (r_state == S_PARITY && w_mid_bit)
                r_par_err_acc <= r_par_acc ^ w_rx_s ^ r_cfg_par_odd;
`endif

            if (r_state == S_STOP && w_mid_bit)
                r_frame_err_acc <= ~w_rx_s;

            // A break leaves the line low; re-arm only once it is seen high.
            if (w_complete)
                r_armed <= w_rx_s;
            else if (r_state == S_IDLE && w_rx_s)
                r_armed <= 1'b1;

            if (w_complete) begin
                if (!r_valid || ready) begin
                    r_dout       <= w_word;
                    r_frame_err  <= w_frame_err_final;
                    r_parity_err <= r_par_err_acc;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun    <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Directed self-checking bench for uart_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_bits_count = 2'd3;
    logic [1:0] parity_type = 2'd0;
    logic       double_stop_bits = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       ready = 1'b0;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    logic [1:0] tick_div = 2'd0;
    int          ovr_cnt = 0;
    int          ovr_base;
    int          n_checks = 0;
    int          n_fails = 0;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_tick      (sample_tick),
        .rx               (rx),
        .data_bits_count  (data_bits_count),
        .parity_type      (parity_type),
        .double_stop_bits (double_stop_bits),
        .dout             (dout),
        .valid            (valid),
        .ready            (ready),
        .frame_err        (frame_err),
        .parity_err       (parity_err),
        .overrun          (overrun),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // One sample tick every 4 clocks.
    always @(negedge clk) begin
        tick_div    = tick_div + 2'd1;
        sample_tick = (tick_div == 2'd0);
    end

    always @(posedge clk) begin
        if (overrun === 1'b1)
            ovr_cnt = ovr_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k = k + 1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    // Config inputs are inverted for the body of the frame: the frame must
    // decode with the settings captured at mid-start.
    task automatic send_frame(input logic [7:0] data, input int nbits,
                              input logic has_par, input logic par_bit,
                              input logic stop_val, input logic has_stop2,
                              input logic stop2_val, input logic end_level);
        logic [1:0] s_bits;
        logic [1:0] s_par;
        logic       s_stop2;
        s_bits  = data_bits_count;
        s_par   = parity_type;
        s_stop2 = double_stop_bits;
        send_bit(1'b0);
        data_bits_count  = ~s_bits;
        parity_type      = ~s_par;
        double_stop_bits = ~s_stop2;
        for (int i = 0; i < nbits; i++)
            send_bit(data[i]);
        if (has_par)
            send_bit(par_bit);
        send_bit(stop_val);
        if (has_stop2)
            send_bit(stop2_val);
        rx               = end_level;
        data_bits_count  = s_bits;
        parity_type      = s_par;
        double_stop_bits = s_stop2;
        #1;
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check_value(tag, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_dout", {24'd0, dout}, 32'd0);
        check_value("rst_valid", {31'd0, valid}, 32'd0);
        check_value("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_value("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check_value("rst_overrun", {31'd0, overrun}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        wait_ticks(4);

        // 8N1 0xA5
        ovr_base = ovr_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_value("a5_valid", {31'd0, valid}, 32'd1);
        check_value("a5_dout", {24'd0, dout}, 32'hA5);
        check_value("a5_frame_err", {31'd0, frame_err}, 32'd0);
        check_value("a5_parity_err", {31'd0, parity_err}, 32'd0);
        check_value("a5_overrun", ovr_cnt - ovr_base, 32'd0);
        consume("a5_consume");
        wait_ticks(4);

        // 5-bit data, two stop bits
        data_bits_count  = 2'd0;
        double_stop_bits = 1'b1;
        parity_type      = 2'b01;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_value("5e2_good_dout", {24'd0, dout}, 32'h13);
        check_value("5e2_good_perr", {31'd0, parity_err}, 32'd0);
        check_value("5e2_good_ferr", {31'd0, frame_err}, 32'd0);
        consume("5e2_good_consume");
        wait_ticks(4);
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_value("5e2_bad_valid", {31'd0, valid}, 32'd1);
        check_value("5e2_bad_dout", {24'd0, dout}, 32'h13);
        check_value("5e2_bad_perr", {31'd0, parity_err}, 32'd1);
        consume("5e2_bad_consume");
        wait_ticks(4);
        send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        send_frame(8'h13, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_value("5n2_dout", {24'd0, dout}, 32'h13);
        check_value("5n2_perr", {31'd0, parity_err}, 32'd0);
        check_value("5n2_ferr", {31'd0, frame_err}, 32'd0);
        consume("5n2_consume");
        wait_ticks(4);
        send_frame(8'h13, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
        check_value("stop2_low_dout", {24'd0, dout}, 32'h13);
        check_value("stop2_low_ferr", {31'd0, frame_err}, 32'd1);
        consume("stop2_low_consume");
        data_bits_count  = 2'd3;
        double_stop_bits = 1'b0;
        parity_type      = 2'b00;
        wait_ticks(4);

        // Start-bit glitch
        rx = 1'b0;
        wait_ticks(4);
        check_value("glitch_busy_hi", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_ticks(12);
        #1;
        check_value("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check_value("glitch_valid", {31'd0, valid}, 32'd0);

        // Stop bit low
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_value("3c_valid", {31'd0, valid}, 32'd1);
        check_value("3c_dout", {24'd0, dout}, 32'h3C);
        check_value("3c_ferr", {31'd0, frame_err}, 32'd1);
        consume("3c_consume");
        wait_ticks(4);

        // Break: line held low well past the stop bit
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_ticks(40);
        #1;
        check_value("brk_valid", {31'd0, valid}, 32'd1);
        check_value("brk_dout", {24'd0, dout}, 32'h00);
        check_value("brk_ferr", {31'd0, frame_err}, 32'd1);
        check_value("brk_busy", {31'd0, busy}, 32'd0);
        consume("brk_consume");
        rx = 1'b1;
        wait_ticks(4);

        // Back-to-back frames, no consumer
        ovr_base = ovr_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_value("ovr_valid", {31'd0, valid}, 32'd1);
        check_value("ovr_dout", {24'd0, dout}, 32'h11);
        check_value("ovr_pulses", ovr_cnt - ovr_base, 32'd1);
        consume("ovr_consume");
        wait_ticks(4);

        // Reset in the middle of the data bits
        ovr_base = ovr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_ticks(30);
        #1;
        check_value("rstmid_valid", {31'd0, valid}, 32'd0);
        check_value("rstmid_busy", {31'd0, busy}, 32'd0);
        check_value("rstmid_ovr", ovr_cnt - ovr_base, 32'd0);
        send_frame(8'h66, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_value("66_valid", {31'd0, valid}, 32'd1);
        check_value("66_dout", {24'd0, dout}, 32'h66);
        check_value("66_ferr", {31'd0, frame_err}, 32'd0);
        check_value("66_perr", {31'd0, parity_err}, 32'd0);
        check_value("66_ovr", ovr_cnt - ovr_base, 32'd0);
        consume("66_consume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
